// File: rtl/soda_dispense_ctrl.sv
// Generic single-clock FIFO used for the vend event queue.
// Latency: a push is visible at out_vld/out_dat the cycle after it is accepted.
// Backpressure: in_rdy drops only when full, unless a pop on the same edge frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [WIDTH-1:0]       in_dat,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [WIDTH-1:0]       out_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign out_vld = (count != '0);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign in_rdy  = (count != FULL_CNT) || out_rdy;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = mem[rd_ptr];

  // Storage array; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_dat;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Plays vend events (pour, coin change) out to the water valve and coin hopper.
// Latency: input pulse in cycle T -> queued end of T, popped end of T+1, valve high from T+2.
// Backpressure: none upstream (full queue drops and sets sticky overflow); hopper paced by coin_req/coin_ack.
// Optional hopper ack timeout with sticky fault when SODA_EJECT_TIMEOUT_EN is defined.
module soda_dispense_ctrl #(
  parameter int DEPTH          = 4,
  parameter int POUR_CYCLES    = 8
`ifdef SODA_EJECT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pour_water,
  input  logic                   change1,
  input  logic                   change2,
  input  logic                   change22,
  output logic                   valve_open,
  output logic                   coin_req,
  output logic                   coin_sel,
  input  logic                   coin_ack,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   fault
);
  typedef struct packed {
    logic       pour;
    logic       n1;
    logic [1:0] n2;
  } vend_ev_t;

  typedef enum logic [1:0] {IDLE, POUR, COIN, GAP} state_t;

  localparam int PW = (POUR_CYCLES > 1) ? $clog2(POUR_CYCLES) : 1;

  vend_ev_t        ev_in;
  vend_ev_t        ev_head;
  logic            ev_vld;
  logic            ev_rdy;
  logic            head_vld;
  logic            head_rdy;
  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   pour_cnt;
  logic [PW-1:0]   pour_cnt_nxt;
  logic            n1;
  logic            n1_nxt;
  logic [1:0]      n2;
  logic [1:0]      n2_nxt;
  logic            coins_owed;
  logic            timeout_hit;

  // change22 is two 2-unit coins, so {change22, change2} is exactly change2 + 2*change22.
  assign ev_in    = '{pour: pour_water, n1: change1, n2: {change22, change2}};
  assign ev_vld   = pour_water || change1 || change2 || change22;
  assign head_rdy = (state == IDLE);

  sync_fifo #(
    .WIDTH ($bits(vend_ev_t)),
    .DEPTH (DEPTH)
  ) u_ev_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (ev_vld),
    .in_rdy  (ev_rdy),
    .in_dat  (ev_in),
    .out_vld (head_vld),
    .out_rdy (head_rdy),
    .out_dat (ev_head),
    .count   (fifo_count)
  );

  assign coins_owed = n1 || (n2 != 2'd0);

  // Sticky flag for events lost to a full queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ev_vld && !ev_rdy) begin
      overflow <= 1'b1;
    end
  end

  // FSM state and working registers for the event being played.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pour_cnt <= '0;
      n1       <= 1'b0;
      n2       <= 2'd0;
    end else begin
      state    <= state_nxt;
      pour_cnt <= pour_cnt_nxt;
      n1       <= n1_nxt;
      n2       <= n2_nxt;
    end
  end

  // Next-state: one event at a time, pour first, then 2-unit coins before 1-unit coins.
  always_comb begin
    state_nxt    = state;
    pour_cnt_nxt = pour_cnt;
    n1_nxt       = n1;
    n2_nxt       = n2;
    case (state)
      IDLE: begin
        if (head_vld) begin
          n1_nxt       = ev_head.n1;
          n2_nxt       = ev_head.n2;
          pour_cnt_nxt = '0;
          if (ev_head.pour) begin
            state_nxt = POUR;
          end else if (ev_head.n1 || (ev_head.n2 != 2'd0)) begin
            state_nxt = COIN;
          end
        end
      end
      POUR: begin
        if (pour_cnt == PW'(POUR_CYCLES - 1)) begin
          state_nxt = coins_owed ? COIN : IDLE;
        end else begin
          pour_cnt_nxt = pour_cnt + 1'b1;
        end
      end
      COIN: begin
        if (coin_ack) begin
          if (n2 != 2'd0) n2_nxt = n2 - 2'd1;
          else            n1_nxt = 1'b0;
          state_nxt = GAP;
        end else if (timeout_hit) begin
          // Hopper is unresponsive: abandon the rest of this event's change.
          n1_nxt    = 1'b0;
          n2_nxt    = 2'd0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        state_nxt = coins_owed ? COIN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only.
  assign valve_open = (state == POUR);
  assign coin_req   = (state == COIN);
  assign coin_sel   = (state == COIN) && (n2 != 2'd0);
  assign busy       = (state != IDLE) || head_vld;

`ifdef SODA_EJECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;

  assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Ack wait counter restarts on every COIN entry; fault latches until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      if (state == COIN) to_cnt <= to_cnt + 1'b1;
      else               to_cnt <= '0;
      if ((state == COIN) && !coin_ack && timeout_hit) fault <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif
endmodule

// File: tb/tb_soda_dispense_ctrl.sv
module tb_soda_dispense_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pour_water = 1'b0;
  logic       change1 = 1'b0;
  logic       change2 = 1'b0;
  logic       change22 = 1'b0;
  logic       coin_ack = 1'b0;
  logic       valve_open, coin_req, coin_sel, busy, overflow, fault;
  logic [2:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;

  // kind 0 = valve pulse, 1 = coin request; len/gap of -1 mean "don't care".
  typedef struct {
    int kind;
    int sel;
    int len;
    int gap;
    bit selchg;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int ack_delay = 0;
  int ack_cnt = 0;
  int cyc = 0, last_fall = 0, vrun = 0, crun = 0, vgap = 0, cgap = 0, csel = 0;
  bit cchg = 0;
  int overlap = 0;

  soda_dispense_ctrl #(
    .DEPTH          (4),
    .POUR_CYCLES    (8)
`ifdef SODA_EJECT_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pour_water (pour_water),
    .change1    (change1),
    .change2    (change2),
    .change22   (change22),
    .valve_open (valve_open),
    .coin_req   (coin_req),
    .coin_sel   (coin_sel),
    .coin_ack   (coin_ack),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Hopper model: acks ack_delay cycles into a request (0 = never).
  always @(negedge clk) begin
    if (coin_req) begin
      ack_cnt  = ack_cnt + 1;
      coin_ack = (ack_delay > 0) && (ack_cnt >= ack_delay);
    end else begin
      ack_cnt  = 0;
      coin_ack = 1'b0;
    end
  end

  // Output monitor: turns valve/coin_req runs into observed events.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      vrun = 0;
      crun = 0;
    end else begin
      if (valve_open && coin_req) overlap = overlap + 1;
      if (valve_open) begin
        if (vrun == 0) vgap = cyc - last_fall;
        vrun = vrun + 1;
      end else if (vrun > 0) begin
        obs_q.push_back('{0, 0, vrun, vgap, 1'b0});
        vrun = 0;
        last_fall = cyc;
      end
      if (coin_req) begin
        if (crun == 0) begin
          cgap = cyc - last_fall;
          csel = int'(coin_sel);
          cchg = 1'b0;
        end else if (int'(coin_sel) != csel) begin
          cchg = 1'b1;
        end
        crun = crun + 1;
      end else if (crun > 0) begin
        obs_q.push_back('{1, csel, crun, cgap, cchg});
        crun = 0;
        last_fall = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic pulse(input logic p, input logic c1, input logic c2, input logic c22);
    pour_water = p; change1 = c1; change2 = c2; change22 = c22;
    @(negedge clk);
    pour_water = 1'b0; change1 = 1'b0; change2 = 1'b0; change22 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || valve_open || coin_req) && n < budget);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({valve_open, coin_req, coin_sel, busy, overflow, fault, fifo_count} !== 9'd0) begin
      $display("FAIL reset_outputs: got %b required 0", {valve_open, coin_req, coin_sel, busy, overflow, fault, fifo_count});
      miscompares++;
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || fifo_count !== 3'd0) begin
      $display("FAIL reset_release: busy=%b count=%0d required 0/0", busy, fifo_count);
      miscompares++;
    end
  endtask

  task automatic test_pour();
    ev_t e, o;
    ack_delay = 0;
    exp_q.push_back('{0, 0, 8, -1, 1'b0});
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      vectors++;
      if (valve_open !== ((k >= 2 && k <= 9) ? 1'b1 : 1'b0)) begin
        $display("FAIL pour_valve T+%0d: got %b required %b", k, valve_open, (k >= 2 && k <= 9));
        miscompares++;
      end
      if (k == 1) begin
        vectors++;
        if (fifo_count !== 3'd1) begin
          $display("FAIL pour_queued: got %0d required 1", fifo_count);
          miscompares++;
        end
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL pour_busy T+10: got %b required 0", busy);
      miscompares++;
    end
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        $display("FAIL pour_sb: no output event, required kind=%0d len=%0d", e.kind, e.len);
        miscompares++;
      end else begin
        o = obs_q.pop_front();
        if (o.kind != e.kind || o.sel != e.sel || o.selchg || (e.len >= 0 && o.len != e.len) || (e.gap >= 0 && o.gap != e.gap)) begin
          $display("FAIL pour_sb: got kind=%0d sel=%0d len=%0d gap=%0d chg=%0d required kind=%0d sel=%0d len=%0d gap=%0d",
                   o.kind, o.sel, o.len, o.gap, o.selchg, e.kind, e.sel, e.len, e.gap);
          miscompares++;
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      $display("FAIL pour_sb_extra: got %0d extra events required 0", obs_q.size());
      miscompares++;
      obs_q.delete();
    end
  endtask

  task automatic test_pour_coins();
    ev_t e, o;
    ack_delay = 1;
    exp_q.push_back('{0, 0, 8, -1, 1'b0});
    exp_q.push_back('{1, 1, 1, 0, 1'b0});
    exp_q.push_back('{1, 0, 1, 1, 1'b0});
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle(200);
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL pour_coins_idle: busy=%b required 0", busy);
      miscompares++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        $display("FAIL pour_coins_sb: no output event, required kind=%0d sel=%0d", e.kind, e.sel);
        miscompares++;
      end else begin
        o = obs_q.pop_front();
        if (o.kind != e.kind || o.sel != e.sel || o.selchg || (e.len >= 0 && o.len != e.len) || (e.gap >= 0 && o.gap != e.gap)) begin
          $display("FAIL pour_coins_sb: got kind=%0d sel=%0d len=%0d gap=%0d chg=%0d required kind=%0d sel=%0d len=%0d gap=%0d",
                   o.kind, o.sel, o.len, o.gap, o.selchg, e.kind, e.sel, e.len, e.gap);
          miscompares++;
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      $display("FAIL pour_coins_sb_extra: got %0d extra events required 0", obs_q.size());
      miscompares++;
      obs_q.delete();
    end
  endtask

  task automatic test_change22();
    ev_t e, o;
    ack_delay = 5;
    exp_q.push_back('{1, 1, 5, -1, 1'b0});
    exp_q.push_back('{1, 1, 5, 1, 1'b0});
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle(200);
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL change22_idle: busy=%b required 0", busy);
      miscompares++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        $display("FAIL change22_sb: no output event, required kind=%0d sel=%0d", e.kind, e.sel);
        miscompares++;
      end else begin
        o = obs_q.pop_front();
        if (o.kind != e.kind || o.sel != e.sel || o.selchg || (e.len >= 0 && o.len != e.len) || (e.gap >= 0 && o.gap != e.gap)) begin
          $display("FAIL change22_sb: got kind=%0d sel=%0d len=%0d gap=%0d chg=%0d required kind=%0d sel=%0d len=%0d gap=%0d",
                   o.kind, o.sel, o.len, o.gap, o.selchg, e.kind, e.sel, e.len, e.gap);
          miscompares++;
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      $display("FAIL change22_sb_extra: got %0d extra events required 0", obs_q.size());
      miscompares++;
      obs_q.delete();
    end
  endtask

  task automatic test_overflow();
    ack_delay = 0;
    change1 = 1'b1;
    repeat (6) @(negedge clk);
    change1 = 1'b0;
    vectors++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      $display("FAIL overflow_full: count=%0d overflow=%b required 4/1", fifo_count, overflow);
      miscompares++;
    end
    vectors++;
    if (coin_req !== 1'b1 || coin_sel !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL overflow_head: req=%b sel=%b busy=%b required 1/0/1", coin_req, coin_sel, busy);
      miscompares++;
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (overflow !== 1'b0 || fifo_count !== 3'd0 || coin_req !== 1'b0) begin
      $display("FAIL overflow_reset: overflow=%b count=%0d req=%b required 0/0/0", overflow, fifo_count, coin_req);
      miscompares++;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || obs_q.size() != 0) begin
      $display("FAIL overflow_after: busy=%b events=%0d required 0/0", busy, obs_q.size());
      miscompares++;
      obs_q.delete();
    end
  endtask

  task automatic test_reset_midpour();
    ack_delay = 0;
    pour_water = 1'b1;
    @(negedge clk);
    pour_water = 1'b0; change1 = 1'b1;
    @(negedge clk);
    change1 = 1'b0; change2 = 1'b1;
    @(negedge clk);
    change2 = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (valve_open !== 1'b1 || fifo_count !== 3'd2) begin
      $display("FAIL midpour_pre: valve=%b count=%0d required 1/2", valve_open, fifo_count);
      miscompares++;
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (valve_open !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0 || overflow !== 1'b0 || coin_req !== 1'b0) begin
      $display("FAIL midpour_reset: valve=%b count=%0d busy=%b ovf=%b req=%b required all 0",
               valve_open, fifo_count, busy, overflow, coin_req);
      miscompares++;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valve_open !== 1'b0 || obs_q.size() != 0) begin
      $display("FAIL midpour_after: busy=%b valve=%b events=%0d required 0/0/0", busy, valve_open, obs_q.size());
      miscompares++;
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    int n;
    ack_delay = 0;
    exp_q.push_back('{1, 0, -1, -1, 1'b0});
    for (int i = 0; i < 5; i++) exp_q.push_back('{1, 0, 1, 2, 1'b0});
    change1 = 1'b1;
    repeat (5) @(negedge clk);
    change1 = 1'b0;
    vectors++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      $display("FAIL b2b_full: count=%0d overflow=%b required 4/0", fifo_count, overflow);
      miscompares++;
    end
    ack_delay = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (coin_req && n < 10);
    vectors++;
    if (coin_req !== 1'b0) begin
      $display("FAIL b2b_ack_wait: coin_req=%b required 0 within 10 cycles", coin_req);
      miscompares++;
    end
    // Now in GAP; the next cycle is IDLE, which pops while this push lands on a full queue.
    @(negedge clk);
    change1 = 1'b1;
    @(negedge clk);
    change1 = 1'b0;
    vectors++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || coin_req !== 1'b1) begin
      $display("FAIL b2b_push_pop_full: count=%0d overflow=%b req=%b required 4/0/1", fifo_count, overflow, coin_req);
      miscompares++;
    end
    wait_idle(300);
    vectors++;
    if (busy !== 1'b0 || overlap != 0) begin
      $display("FAIL b2b_idle: busy=%b overlap=%0d required 0/0", busy, overlap);
      miscompares++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        $display("FAIL b2b_sb: no output event, required kind=%0d sel=%0d", e.kind, e.sel);
        miscompares++;
      end else begin
        o = obs_q.pop_front();
        if (o.kind != e.kind || o.sel != e.sel || o.selchg || (e.len >= 0 && o.len != e.len) || (e.gap >= 0 && o.gap != e.gap)) begin
          $display("FAIL b2b_sb: got kind=%0d sel=%0d len=%0d gap=%0d chg=%0d required kind=%0d sel=%0d len=%0d gap=%0d",
                   o.kind, o.sel, o.len, o.gap, o.selchg, e.kind, e.sel, e.len, e.gap);
          miscompares++;
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      $display("FAIL b2b_sb_extra: got %0d extra events required 0", obs_q.size());
      miscompares++;
      obs_q.delete();
    end
  endtask

`ifdef SODA_EJECT_TIMEOUT_EN
  task automatic test_timeout();
    ev_t e, o;
    ack_delay = 0;
    exp_q.push_back('{1, 1, 16, -1, 1'b0});
    exp_q.push_back('{0, 0, 8, 2, 1'b0});
    change22 = 1'b1;
    @(negedge clk);
    change22 = 1'b0; pour_water = 1'b1;
    @(negedge clk);
    pour_water = 1'b0;
    vectors++;
    if (fault !== 1'b0) begin
      $display("FAIL timeout_early: fault=%b required 0", fault);
      miscompares++;
    end
    wait_idle(300);
    vectors++;
    if (fault !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL timeout_fault: fault=%b busy=%b required 1/0", fault, busy);
      miscompares++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        $display("FAIL timeout_sb: no output event, required kind=%0d sel=%0d", e.kind, e.sel);
        miscompares++;
      end else begin
        o = obs_q.pop_front();
        if (o.kind != e.kind || o.sel != e.sel || o.selchg || (e.len >= 0 && o.len != e.len) || (e.gap >= 0 && o.gap != e.gap)) begin
          $display("FAIL timeout_sb: got kind=%0d sel=%0d len=%0d gap=%0d chg=%0d required kind=%0d sel=%0d len=%0d gap=%0d",
                   o.kind, o.sel, o.len, o.gap, o.selchg, e.kind, e.sel, e.len, e.gap);
          miscompares++;
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      $display("FAIL timeout_sb_extra: got %0d extra events required 0", obs_q.size());
      miscompares++;
      obs_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pour();
    test_pour_coins();
    test_change22();
    test_overflow();
    test_reset_midpour();
    test_back_to_back();
`ifdef SODA_EJECT_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
